bcd_add_sequencer: RTL and testbench

// Controller end of the BCD adder request/acknowledge interface. Walks the datapath through

---
 rtl/bcd_add_sequencer.sv | 149 ++++++++++++++
 tb/tb_bcd_add_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_add_sequencer.sv
// Step-button driven request/ack sequencer for the BCD adder datapath.
// Optional auto-advance in WAIT is enabled by defining BCD_AUTO_STEP_EN.
//
// state   | meaning
// S_IDLE  | nothing requested, waiting for the first step press
// S_REQ   | one request held high, waiting for its ack (timeout counter running)
// S_WAIT  | phase acknowledged, waiting for step (or dwell expiry) to advance
// S_ERROR | ack never came; held until abort
module bcd_add_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int DWELL_CYCLES   = 200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       step_btn,
  input  logic       abort_btn,
  input  logic       load_a_ack,
  input  logic       load_b_ack,
  input  logic       display_a_ack,
  input  logic       display_b_ack,
  input  logic       display_ls_ack,
  input  logic       display_ms_ack,
  output logic       load_a,
  output logic       load_b,
  output logic       display_a,
  output logic       display_b,
  output logic       display_ls,
  output logic       display_ms,
  output logic [2:0] phase,
  output logic       busy,
  output logic       error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERROR} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1 ||
      DWELL_CYCLES < 1 || DWELL_CYCLES > (2 ** CNT_W) - 1) begin : g_param_check
    $error("bcd_add_sequencer: TIMEOUT_CYCLES/DWELL_CYCLES do not fit CNT_W");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       req;
  logic             step_s1, step_s2, step_prev;
  logic             abort_s1, abort_s2;
  logic             step_edge, ack_hit, done, advance;
  logic [7:0]       ack_vec;
  logic [2:0]       next_phase;

  function automatic logic [5:0] phase_req(input logic [2:0] p);
    return 6'b000001 << p;
  endfunction

  // Request/ack bit index equals the phase number.
  assign {display_ms, display_ls, display_b, load_b, display_a, load_a} = req;
  assign ack_vec = {2'b00, display_ms_ack, display_ls_ack, display_b_ack,
                    load_b_ack, display_a_ack, load_a_ack};

  assign step_edge  = step_s2 & ~step_prev;
  assign ack_hit    = ack_vec[phase];
  // cnt is 0 only in the first REQ cycle, so a nonzero count means the request
  // has already been visible to the datapath for at least one edge.
  assign done       = ack_hit && (cnt != '0);
  assign next_phase = (phase == 3'd5) ? 3'd0 : phase + 3'd1;

`ifdef BCD_AUTO_STEP_EN
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  assign advance = step_edge || (cnt == DWELL_LAST);
`else
  assign advance = step_edge;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      phase     <= 3'd0;
      req       <= 6'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      cnt       <= '0;
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_prev <= 1'b0;
      abort_s1  <= 1'b0;
      abort_s2  <= 1'b0;
    end else begin
      step_s1   <= step_btn;
      step_s2   <= step_s1;
      step_prev <= step_s2;
      abort_s1  <= abort_btn;
      abort_s2  <= abort_s1;
      if (abort_s2) begin
        state <= S_IDLE;
        phase <= 3'd0;
        req   <= 6'b0;
        busy  <= 1'b0;
        error <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (step_edge) begin
              state <= S_REQ;
              phase <= 3'd0;
              req   <= phase_req(3'd0);
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          S_REQ: begin
            if (done) begin
              state <= S_WAIT;
              req   <= 6'b0;
              busy  <= 1'b0;
              cnt   <= '0;
            end else if (cnt == TO_LAST) begin
              state <= S_ERROR;
              req   <= 6'b0;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (advance) begin
              state <= S_REQ;
              phase <= next_phase;
              req   <= phase_req(next_phase);
              busy  <= 1'b1;
              cnt   <= '0;
            end
`ifdef BCD_AUTO_STEP_EN
            else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end
          S_ERROR: state <= S_ERROR;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Self-checking bench for bcd_add_sequencer: directed phase walk, timeout, sticky
// and wrong acks, async reset, then randomized buttons/acks against a reference model.
module tb_bcd_add_sequencer;
  localparam int TO = 8;
  localparam int DW = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       step_btn = 1'b0;
  logic       abort_btn = 1'b0;
  logic [5:0] ack = 6'b0;
  logic       load_a, load_b, display_a, display_b, display_ls, display_ms;
  logic [2:0] phase;
  logic       busy, error;
  logic [5:0] req_out;

  int vectors = 0;
  int miscompares = 0;
  int resp_mode = 0;

  always #5 CLK = ~CLK;

  bcd_add_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(8), .DWELL_CYCLES(DW)) dut (
    .CLK(CLK), .RST(RST), .step_btn(step_btn), .abort_btn(abort_btn),
    .load_a_ack(ack[0]), .load_b_ack(ack[2]), .display_a_ack(ack[1]),
    .display_b_ack(ack[3]), .display_ls_ack(ack[4]), .display_ms_ack(ack[5]),
    .load_a(load_a), .load_b(load_b), .display_a(display_a), .display_b(display_b),
    .display_ls(display_ls), .display_ms(display_ms),
    .phase(phase), .busy(busy), .error(error)
  );

  // Request index order is the phase order: A-load, A-disp, B-load, B-disp, LS, MS.
  assign req_out = {display_ms, display_ls, display_b, load_b, display_a, load_a};

  // Reference model: button history, which phase is outstanding and for how long.
  bit step_hist[3];
  bit abort_hist[2];
  bit m_active, m_waiting, m_err;
  int m_phase, m_age, m_dwell;

  always @(posedge CLK or posedge RST) begin
    bit e_now, ab_now, adv;
    if (RST) begin
      step_hist = '{0, 0, 0};
      abort_hist = '{0, 0};
      m_active = 0; m_waiting = 0; m_err = 0;
      m_phase = 0; m_age = 0; m_dwell = 0;
    end else begin
      e_now  = step_hist[1] && !step_hist[2];
      ab_now = abort_hist[1];
      step_hist[2] = step_hist[1];
      step_hist[1] = step_hist[0];
      step_hist[0] = step_btn;
      abort_hist[1] = abort_hist[0];
      abort_hist[0] = abort_btn;
`ifdef BCD_AUTO_STEP_EN
      adv = e_now || (m_dwell + 1 == DW);
`else
      adv = e_now;
`endif
      if (ab_now) begin
        m_active = 0; m_waiting = 0; m_err = 0; m_phase = 0;
      end else if (m_err) begin
        m_err = 1;
      end else if (m_active) begin
        if (ack[m_phase] && m_age >= 1) begin
          m_active = 0; m_waiting = 1; m_dwell = 0;
        end else if (m_age + 1 == TO) begin
          m_active = 0; m_err = 1;
        end else begin
          m_age++;
        end
      end else if (m_waiting) begin
        if (adv) begin
          m_phase = (m_phase + 1) % 6;
          m_active = 1; m_waiting = 0; m_age = 0;
        end else begin
          m_dwell++;
        end
      end else if (e_now) begin
        m_phase = 0; m_active = 1; m_age = 0;
      end
    end
  end

  always @(negedge CLK) begin
    logic [5:0]  exp_req;
    logic [10:0] exp_v, act_v;
    if (!RST) begin
      exp_req = m_active ? (6'b000001 << m_phase) : 6'b000000;
      exp_v = {exp_req, 3'(m_phase), m_active, m_err};
      act_v = {req_out, phase, busy, error};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t: got req=%b phase=%0d busy=%b error=%b, expected req=%b phase=%0d busy=%b error=%b",
                 $time, act_v[10:5], act_v[4:2], act_v[1], act_v[0],
                 exp_v[10:5], exp_v[4:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // Datapath responder: echo requests one cycle later, or random (including stray) acks.
  always @(posedge CLK) begin
    #1;
    if (resp_mode == 1) ack = req_out;
    else if (resp_mode == 2) ack = 6'($urandom);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int exp_phase);
    logic [5:0] oh;
    oh = 6'b000001 << exp_phase;
    step_btn = 1'b1;
    tick(3);
    lit("press_req", int'(req_out), int'(oh));
    lit("press_phase", int'(phase), exp_phase);
    tick(1);
    step_btn = 1'b0;
    tick(4);
  endtask

  task automatic do_abort();
    abort_btn = 1'b1;
    tick(3);
    lit("abort_error", int'(error), 0);
    lit("abort_phase", int'(phase), 0);
    lit("abort_busy", int'(busy), 0);
    abort_btn = 1'b0;
    tick(3);
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    lit("reset_req", int'(req_out), 0);
    lit("reset_phase", int'(phase), 0);
    lit("reset_busy", int'(busy), 0);
    lit("reset_error", int'(error), 0);
    RST = 1'b0;
    tick(2);

    // First press: two sync stages plus edge detect before load_a rises.
    resp_mode = 1;
    step_btn = 1'b1;
    tick(2);
    lit("no_req_before_sync", int'(load_a), 0);
    tick(1);
    lit("load_a_after_step", int'(load_a), 1);
    lit("first_phase", int'(phase), 0);
    lit("first_busy", int'(busy), 1);
    tick(1);
    step_btn = 1'b0;
    tick(4);
    for (int i = 1; i <= 6; i++) press(i % 6);

    // No ack: exactly TO cycles of REQ then ERROR; step ignored; abort recovers.
    do_abort();
    resp_mode = 0;
    ack = 6'b0;
    step_btn = 1'b1;
    tick(3);
    lit("to_req_up", int'(load_a), 1);
    tick(1);
    step_btn = 1'b0;
    tick(6);
    lit("to_not_yet_error", int'(error), 0);
    lit("to_not_yet_req", int'(load_a), 1);
    tick(1);
    lit("to_error", int'(error), 1);
    lit("to_req_dropped", int'(load_a), 0);
    step_btn = 1'b1;
    tick(4);
    step_btn = 1'b0;
    tick(4);
    lit("error_ignores_step", int'(error), 1);
    lit("error_no_busy", int'(busy), 0);
    do_abort();

    // Sticky ack held before the request: done no earlier than the second REQ cycle.
    ack = 6'b000001;
    step_btn = 1'b1;
    tick(3);
    lit("sticky_req_up", int'(load_a), 1);
    tick(1);
    lit("sticky_not_first_cycle", int'(busy), 1);
    tick(1);
    lit("sticky_done", int'(busy), 0);
    step_btn = 1'b0;
    tick(4);
    ack = 6'b0;

    // Only load_b_ack while load_a is requested: must stay in REQ.
    do_abort();
    ack = 6'b000100;
    step_btn = 1'b1;
    tick(4);
    step_btn = 1'b0;
    tick(2);
    lit("wrong_ack_ignored", int'(load_a), 1);
    ack = 6'b000101;
    tick(2);
    lit("right_ack_done", int'(busy), 0);
    ack = 6'b0;
    tick(2);

    // Async reset while display_b is requested.
    resp_mode = 1;
    press(1);
    press(2);
    resp_mode = 0;
    ack = 6'b0;
    step_btn = 1'b1;
    tick(3);
    lit("display_b_up", int'(display_b), 1);
    #2;
    RST = 1'b1;
    #1;
    lit("async_rst_drop", int'(display_b), 0);
    lit("async_rst_all_low", int'(req_out), 0);
    step_btn = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tick(2);
    lit("after_rst_phase", int'(phase), 0);
    lit("after_rst_busy", int'(busy), 0);

    // Randomized buttons and acks checked cycle by cycle against the model.
    resp_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) step_btn = ~step_btn;
      if (abort_btn) abort_btn = ($urandom_range(0, 1) == 0);
      else abort_btn = ($urandom_range(0, 59) == 0);
      tick(1);
    end
    resp_mode = 0;
    abort_btn = 1'b0;
    step_btn = 1'b0;
    ack = 6'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
